// File: rtl/auth_ctrl.sv
// auth_ctrl -- key-gated power controller fed by a UART byte stream.
//
// A rider types a KEY_LEN-byte key. A correct key arms the block, and
// GO_CODE then powers the drive. STOP_CODE powers down at once if the
// rider is already off the platform. Otherwise the block waits in a
// disconnect state until rider_off rises, and GO_CODE reconnects from
// there without a new key. MAX_FAIL consecutive bad keys cause a lockout
// of LOCK_CYC cycles. Every accepted byte is acknowledged, including
// bytes that are ignored.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   rx_data    received byte
//   rx_rdy     rx_data is valid and unconsumed
//   clr_rdy    one-cycle acknowledge: the byte was consumed
//   rider_off  high when no rider is on the platform
//   pwr_up     drive electronics enable
//   locked     high during lockout
//   key_err    one-cycle pulse when a key is rejected
module auth_ctrl #(
    parameter int                   KEY_LEN   = 2,
    parameter logic [8*KEY_LEN-1:0] KEY       = 16'h3135,
    parameter logic [7:0]           GO_CODE   = 8'h47,
    parameter logic [7:0]           STOP_CODE = 8'h53,
    parameter int                   MAX_FAIL  = 3,
    parameter int                   LOCK_CYC  = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_rdy,
    output logic       clr_rdy,
    input  logic       rider_off,
    output logic       pwr_up,
    output logic       locked,
    output logic       key_err
);

    localparam int               LOCK_W    = $clog2(LOCK_CYC);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYC - 1);
    localparam logic [3:0]       FAIL_LIM  = 4'(MAX_FAIL);
    localparam logic [2:0]       IDX_LAST  = 3'(KEY_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_ARMED,
        S_PWR,
        S_DISC,
        S_LOCK
    } state_t;

    state_t            state, state_nxt;
    logic [2:0]        idx, idx_nxt;
    logic              bad, bad_nxt;
    logic [3:0]        fail_cnt, fail_nxt;
    logic [LOCK_W-1:0] lock_cnt, lock_nxt;
    logic              key_err_nxt;

    logic              accept;
    logic [2:0]        cmp_idx;
    logic              entry_bad;
    logic              entry_last;
    logic [3:0]        fail_inc;

    // Byte 0 of the key is the most significant byte of KEY.
    function automatic logic [7:0] key_byte(input logic [2:0] i);
        key_byte = 8'h00;
        for (int k = 0; k < KEY_LEN; k++) begin
            if (i == 3'(k)) key_byte = KEY[8*(KEY_LEN-1-k) +: 8];
        end
    endfunction

    // clr_rdy is still high in the cycle after an acceptance. Gating on it
    // keeps a byte that the receiver has not yet dropped from being counted
    // twice.
    assign accept = rx_rdy & ~clr_rdy;

    // Key entry starts in IDLE with byte 0. In KEY, idx selects the byte.
    assign cmp_idx    = (state == S_IDLE) ? 3'd0 : idx;
    assign entry_bad  = (rx_data != key_byte(cmp_idx)) | ((state == S_KEY) & bad);
    assign entry_last = (cmp_idx == IDX_LAST);
    assign fail_inc   = (fail_cnt == 4'hF) ? 4'hF : fail_cnt + 4'd1;

    assign pwr_up = (state == S_PWR) || (state == S_DISC);
    assign locked = (state == S_LOCK);

    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path can leave a value unassigned and infer a latch.
        state_nxt   = state;
        idx_nxt     = idx;
        bad_nxt     = bad;
        fail_nxt    = fail_cnt;
        lock_nxt    = lock_cnt;
        key_err_nxt = 1'b0;

        case (state)
            S_IDLE, S_KEY: begin
                if (accept) begin
                    if (entry_last) begin
                        idx_nxt = 3'd0;
                        bad_nxt = 1'b0;
                        if (!entry_bad) begin
                            fail_nxt  = 4'd0;
                            state_nxt = S_ARMED;
                        end else begin
                            key_err_nxt = 1'b1;
                            fail_nxt    = fail_inc;
                            if (fail_inc >= FAIL_LIM) begin
                                lock_nxt  = '0;
                                state_nxt = S_LOCK;
                            end else begin
                                state_nxt = S_IDLE;
                            end
                        end
                    end else begin
                        idx_nxt   = cmp_idx + 3'd1;
                        bad_nxt   = entry_bad;
                        state_nxt = S_KEY;
                    end
                end
            end
            S_ARMED: begin
                if (accept) state_nxt = (rx_data == GO_CODE) ? S_PWR : S_IDLE;
            end
            S_PWR: begin
                if (accept && rx_data == STOP_CODE)
                    state_nxt = rider_off ? S_IDLE : S_DISC;
            end
            S_DISC: begin
                // rider_off wins over a simultaneous GO_CODE.
                if (rider_off)                         state_nxt = S_IDLE;
                else if (accept && rx_data == GO_CODE) state_nxt = S_PWR;
            end
            S_LOCK: begin
                // lock_cnt is 0 in the first LOCK cycle. The exit fires after
                // exactly LOCK_CYC cycles in LOCK.
                if (lock_cnt == LOCK_LAST) begin
                    lock_nxt  = '0;
                    fail_nxt  = 4'd0;
                    state_nxt = S_IDLE;
                end else begin
                    lock_nxt = lock_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: this block uses non-blocking assignments, so all registers
        // update together from the values they had before the edge.
        if (rst) begin
            state    <= S_IDLE;
            idx      <= 3'd0;
            bad      <= 1'b0;
            fail_cnt <= 4'd0;
            lock_cnt <= '0;
            clr_rdy  <= 1'b0;
            key_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            bad      <= bad_nxt;
            fail_cnt <= fail_nxt;
            lock_cnt <= lock_nxt;
            clr_rdy  <= accept;
            key_err  <= key_err_nxt;
        end
    end

endmodule

// File: tb/tb_auth_ctrl.sv
// Testbench for auth_ctrl (KEY_LEN=2, KEY=16'h3135, LOCK_CYC=16).
// A behavioural model tracks the typed key bytes in a queue, together with
// the power condition, the lockout time left and the run of failures. It
// updates on every rising edge. A compare process checks every DUT output
// against the model on each falling edge. Directed scenarios add literal
// expectations.
module tb_auth_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rdy = 1'b0;
    logic       rider_off = 1'b0;
    logic       clr_rdy, pwr_up, locked, key_err;

    auth_ctrl #(
        .KEY_LEN  (2),
        .KEY      (16'h3135),
        .GO_CODE  (8'h47),
        .STOP_CODE(8'h53),
        .MAX_FAIL (3),
        .LOCK_CYC (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_rdy   (rx_rdy),
        .clr_rdy  (clr_rdy),
        .rider_off(rider_off),
        .pwr_up   (pwr_up),
        .locked   (locked),
        .key_err  (key_err)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] key_b [2] = '{8'h31, 8'h35};
    logic [7:0] typed [$];
    int  m_power;      // 0 off, 1 powered, 2 powered and waiting for rider_off
    bit  m_armed;
    int  m_lock_left;
    int  m_fails;
    bit  m_clr, m_kerr;

    task automatic model_step();
        bit acc;
        bit good;
        acc    = rx_rdy && !m_clr;
        m_kerr = 1'b0;
        if (rst) begin
            acc = 1'b0;
            m_power = 0; m_armed = 0; m_lock_left = 0; m_fails = 0;
            typed.delete();
        end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fails = 0;
        end else if (m_power == 2) begin
            if (rider_off)                        m_power = 0;
            else if (acc && rx_data == 8'h47)     m_power = 1;
        end else if (m_power == 1) begin
            if (acc && rx_data == 8'h53)          m_power = rider_off ? 0 : 2;
        end else if (m_armed) begin
            if (acc) begin
                m_armed = 0;
                if (rx_data == 8'h47) m_power = 1;
            end
        end else if (acc) begin
            typed.push_back(rx_data);
            if (typed.size() == 2) begin
                good = 1'b1;
                for (int i = 0; i < 2; i++) if (typed[i] != key_b[i]) good = 1'b0;
                typed.delete();
                if (good) begin
                    m_fails = 0;
                    m_armed = 1;
                end else begin
                    m_kerr  = 1'b1;
                    m_fails = (m_fails < 15) ? m_fails + 1 : 15;
                    if (m_fails >= 3) m_lock_left = 16;
                end
            end
        end
        m_clr = acc;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- compare process and event counters ----------------
    bit cmp_en = 1'b0;
    int clr_cnt = 0, ke_cnt = 0, lock_high = 0;

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("clr_rdy",  32'(clr_rdy),      32'(m_clr));
            check("pwr_up",   32'(pwr_up),       32'(m_power != 0));
            check("locked",   32'(locked),       32'(m_lock_left > 0));
            check("key_err",  32'(key_err),      32'(m_kerr));
            check("fail_cnt", 32'(dut.fail_cnt), 32'(m_fails));
        end
        if (clr_rdy === 1'b1) clr_cnt++;
        if (key_err === 1'b1) ke_cnt++;
        if (locked  === 1'b1) lock_high++;
    end

    // ---------------- stimulus helpers (called at a falling edge) ----------------
    task automatic do_reset();
        rst = 1'b1; rx_rdy = 1'b0; rider_off = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one byte and returns at the falling edge just after the
    // acceptance edge.
    task automatic send_byte(input logic [7:0] b, input logic ro);
        int guard = 0;
        while (clr_rdy === 1'b1 && guard < 4) begin
            @(negedge clk);
            guard++;
        end
        rx_data = b; rx_rdy = 1'b1; rider_off = ro;
        @(negedge clk);
        rx_rdy = 1'b0; rider_off = 1'b0;
    endtask

    task automatic power_on();
        send_byte(8'h31, 1'b0);
        send_byte(8'h35, 1'b0);
        send_byte(8'h47, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        @(negedge clk);
        do_reset();
        cmp_en = 1'b1;
        check("rst_clr_rdy", 32'(clr_rdy), 32'd0);
        check("rst_pwr_up",  32'(pwr_up),  32'd0);
        check("rst_locked",  32'(locked),  32'd0);
        check("rst_key_err", 32'(key_err), 32'd0);

        // Good key then GO: one acknowledge per byte, power one cycle after GO.
        clr_cnt = 0;
        send_byte(8'h31, 1'b0);
        send_byte(8'h35, 1'b0);
        check("armed_pwr_off", 32'(pwr_up), 32'd0);
        send_byte(8'h47, 1'b0);
        check("go_pwr_up", 32'(pwr_up), 32'd1);
        @(negedge clk);
        check("clr_pulses", 32'(clr_cnt), 32'd3);

        // GO from IDLE starts key entry: GO,0x31 is a bad key and 0x30 opens the next.
        do_reset();
        ke_cnt = 0;
        send_byte(8'h47, 1'b0);
        send_byte(8'h31, 1'b0);
        send_byte(8'h30, 1'b0);
        @(negedge clk);
        check("badkey_pwr", 32'(pwr_up), 32'd0);
        check("badkey_err_pulses", 32'(ke_cnt), 32'd1);
        check("badkey_fail_cnt", 32'(dut.fail_cnt), 32'd1);

        // Three bad keys cause a lockout of 16 cycles. Bytes sent during it are ignored.
        do_reset();
        lock_high = 0;
        for (int k = 0; k < 3; k++) begin
            send_byte(8'h30, 1'b0);
            send_byte(8'h30, 1'b0);
        end
        check("lock_entered", 32'(locked), 32'd1);
        power_on();
        check("lock_ignores_key", 32'(pwr_up), 32'd0);
        g = 0;
        while (locked === 1'b1 && g < 60) begin
            @(negedge clk);
            g++;
        end
        check("lock_released", 32'(locked), 32'd0);
        check("lock_cycles", 32'(lock_high), 32'd16);
        check("lock_fail_clr", 32'(dut.fail_cnt), 32'd0);
        check("after_lock_pwr", 32'(pwr_up), 32'd0);

        // STOP with the rider on goes to DISC. GO reconnects. rider_off then drops power.
        do_reset();
        power_on();
        send_byte(8'h53, 1'b0);
        check("disc_pwr_up", 32'(pwr_up), 32'd1);
        send_byte(8'h47, 1'b0);
        check("reconnect_pwr", 32'(pwr_up), 32'd1);
        send_byte(8'h53, 1'b0);
        rider_off = 1'b1;
        @(negedge clk);
        rider_off = 1'b0;
        check("disc_rider_off", 32'(pwr_up), 32'd0);

        // In DISC, rider_off beats a simultaneous GO.
        power_on();
        send_byte(8'h53, 1'b0);
        send_byte(8'h47, 1'b1);
        check("disc_go_vs_rider", 32'(pwr_up), 32'd0);

        // STOP with rider_off=1 powers down at once. A lone GO does not restore power.
        do_reset();
        power_on();
        send_byte(8'h53, 1'b1);
        check("stop_rider_off", 32'(pwr_up), 32'd0);
        send_byte(8'h47, 1'b0);
        @(negedge clk);
        check("lone_go", 32'(pwr_up), 32'd0);

        // Reset in PWR, then a full key and GO power up again.
        do_reset();
        power_on();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_pwr", 32'(pwr_up), 32'd0);
        power_on();
        check("repower", 32'(pwr_up), 32'd1);

        // Random traffic against the model. The byte alphabet is biased
        // toward the key and the command codes.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 499) == 0);
            rx_rdy    = $urandom_range(0, 1) == 1;
            rider_off = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 5))
                0:       rx_data = 8'h31;
                1:       rx_data = 8'h35;
                2:       rx_data = 8'h47;
                3:       rx_data = 8'h53;
                4:       rx_data = 8'h30;
                default: rx_data = 8'($urandom);
            endcase
            @(negedge clk);
        end
        rst = 1'b0; rx_rdy = 1'b0; rider_off = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
